// File: rtl/multibyte_add_ctrl.sv
// Byte-serial sequencer that drives one external 8-bit adder to add two NBYTES-wide operands, LSB byte first.
// Optional feature macro OVERFLOW_FLAG_EN adds a registered two's-complement overflow output ovf.
module multibyte_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
`ifdef OVERFLOW_FLAG_EN
  output logic                  ovf,
`endif
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic [NBYTES-1:0][7:0]  a_q, a_d;
  logic [NBYTES-1:0][7:0]  b_q, b_d;
  logic [NBYTES-1:0][7:0]  sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef OVERFLOW_FLAG_EN
  logic                    ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_sum;
        carry_d      = add_cout;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
`ifdef OVERFLOW_FLAG_EN
          // Signed overflow: equal operand signs but result sign differs.
          ovf_d   = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                    (add_sum[7] != a_q[NBYTES-1][7]);
`endif
          idx_d   = '0;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Adder operands come only from registers, so there is no combinational loop through the adder.
  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[idx_q];
      add_b   = b_q[idx_q];
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Self-checking bench for multibyte_add_ctrl: known vectors, corner sequences and random operands
// checked against plain wide-integer arithmetic. Define OVERFLOW_FLAG_EN to also check ovf.
module tb_multibyte_add_ctrl;

  localparam int NBYTES  = 4;
  localparam int W       = 8 * NBYTES;
  localparam int TIMEOUT = 4 * NBYTES + 8;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] expSum;
  logic         expCout;
  logic         expOvf;
  logic [W-1:0] gotSum;
  logic         gotCout;
  logic         gotOvf;
  bit           opFinished;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vecs[7];

  multibyte_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
`ifdef OVERFLOW_FLAG_EN
    .ovf      (ovf),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Stand-in for the external 8-bit adder the controller time-shares.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " done"}, 64'(done), 64'd0);
    checkOutput({tag, " sum"}, 64'(sum), 64'd0);
    checkOutput({tag, " cout"}, 64'(cout), 64'd0);
    checkOutput({tag, " add_a"}, 64'(add_a), 64'd0);
    checkOutput({tag, " add_b"}, 64'(add_b), 64'd0);
    checkOutput({tag, " add_cin"}, 64'(add_cin), 64'd0);
`ifdef OVERFLOW_FLAG_EN
    checkOutput({tag, " ovf"}, 64'(ovf), 64'd0);
`endif
  endtask

  // Drives one request at a negedge and follows it to done. Optionally pulses a
  // distracting start at RUN sample injectAt, or pulls reset at RUN sample resetAt.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tcin,
                               input int injectAt, input int resetAt, input string tag);
    logic [W:0] full;
    logic [W:0] mask;
    logic [W:0] part;
    int n;
    int busyCount;
    full    = {1'b0, ta} + {1'b0, tbv} + (W+1)'(tcin);
    expSum  = full[W-1:0];
    expCout = full[W];
    expOvf  = (ta[W-1] == tbv[W-1]) && (expSum[W-1] != ta[W-1]);
    opFinished = 1'b0;
    start = 1'b1; a = ta; b = tbv; cin = tcin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; cin = 1'b0;
    n = 0;
    busyCount = 0;
    while (!done && n < TIMEOUT) begin
      if (busy) busyCount++;
      if (n < NBYTES) begin
        mask = ((W+1)'(1) << (8 * n)) - 1'b1;
        part = ({1'b0, ta} & mask) + ({1'b0, tbv} & mask) + (W+1)'(tcin);
        checkOutput($sformatf("%s add_a[%0d]", tag, n), 64'(add_a), 64'(ta[8*n +: 8]));
        checkOutput($sformatf("%s add_b[%0d]", tag, n), 64'(add_b), 64'(tbv[8*n +: 8]));
        checkOutput($sformatf("%s add_cin[%0d]", tag, n), 64'(add_cin), 64'(part[8*n]));
      end
      if (n == resetAt) begin
        reset_n = 1'b0;
        #1;
        checkResetState({tag, " async reset"});
        return;
      end
      if (n == injectAt) begin
        start = 1'b1; a = ~ta; b = ~tbv; cin = ~tcin;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput({tag, " latency"}, 64'(n), 64'(NBYTES));
    checkOutput({tag, " busy cycles"}, 64'(busyCount), 64'(NBYTES));
    checkOutput({tag, " done"}, 64'(done), 64'd1);
    if (!done) return;
    gotSum  = sum;
    gotCout = cout;
    checkOutput({tag, " sum"}, 64'(sum), 64'(expSum));
    checkOutput({tag, " cout"}, 64'(cout), 64'(expCout));
    checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
    checkOutput({tag, " add_a at done"}, 64'(add_a), 64'd0);
`ifdef OVERFLOW_FLAG_EN
    gotOvf = ovf;
    checkOutput({tag, " ovf"}, 64'(ovf), 64'(expOvf));
`else
    gotOvf = expOvf;
`endif
    opFinished = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    cin     = 1'b0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 32'h2143_6588, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle busy", 64'(busy), 64'd0);

    // Known vectors, each followed by an idle cycle to see done drop and sum hold.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vcin, -1, -1, $sformatf("vec%0d", i));
      if (opFinished) begin
        checkOutput($sformatf("vec%0d table sum", i), 64'(gotSum), 64'(vecs[i].esum));
        checkOutput($sformatf("vec%0d table cout", i), 64'(gotCout), 64'(vecs[i].ecout));
`ifdef OVERFLOW_FLAG_EN
        checkOutput($sformatf("vec%0d table ovf", i), 64'(gotOvf), 64'(vecs[i].eovf));
`endif
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d done width", i), 64'(done), 64'd0);
      checkOutput($sformatf("vec%0d sum held", i), 64'(sum), 64'(vecs[i].esum));
    end

    // A start pulse in the middle of RUN must be ignored.
    applyStimulus(32'h1111_2222, 32'h3333_4444, 1'b0, 2, -1, "ignore");
    checkOutput("ignore const sum", 64'(gotSum), 64'h4444_6666);
    @(negedge clk);
    checkOutput("ignore no restart", 64'(busy), 64'd0);

    // Back-to-back: the second request is raised during the done cycle.
    applyStimulus(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, -1, -1, "b2b first");
    applyStimulus(32'h0102_0304, 32'h1020_3040, 1'b1, -1, -1, "b2b second");
    checkOutput("b2b const sum", 64'(gotSum), 64'h1122_3345);
    @(negedge clk);

    // Reset during the third RUN cycle aborts without a done pulse.
    applyStimulus(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, -1, 2, "abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort no done", 64'(done), 64'd0);
    end
    checkResetState("abort held");
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, -1, -1, "after abort");
    checkOutput("after abort const sum", 64'(gotSum), 64'h0000_0100);
    checkOutput("after abort const cout", 64'(gotCout), 64'd0);

    // Random operands, sometimes back-to-back, against wide-integer arithmetic.
    for (int i = 0; i < 30; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), -1, -1, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
